// File: rtl/key4_enc_if.sv
// key4_enc_if: event handshake between the key encoder (master) and the
// downstream 2-to-4 decoder (slave). The head entry's code and rel are
// presented together with code_vld, and the slave accepts an entry with code_rdy.
interface key4_enc_if;
   logic [1:0] code;
   logic       code_vld;
   logic       code_rdy;
   logic       rel;

   modport master (output code, output code_vld, output rel, input code_rdy);
   modport slave  (input code, input code_vld, input rel, output code_rdy);
endinterface

// File: rtl/key4_enc.sv
// key4_enc: debounced 4-key event encoder.
// Flow: 2-flop sync -> per-key debounce -> edge detect into the pending mask
// -> priority push (lowest index first) -> event FIFO -> valid/ready head.
// Optional macro KEY4_ENC_RELEASE_EN: release edges also become events (rel=1).
module key4_enc #(
   parameter int DEB_CYCLES = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key,
   key4_enc_if.master bus,
   output logic       ovf,
   input  logic       ovf_clr
);

`ifdef KEY4_ENC_RELEASE_EN
   localparam int NP = 8;   // press bits [3:0], release bits [7:4]
   localparam int IW = 3;   // stored entry is {rel, code}
`else
   localparam int NP = 4;
   localparam int IW = 2;
`endif
   localparam int         PW      = $clog2(FIFO_DEPTH);
   localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

   logic [3:0]    r_sync_p0;
   logic [3:0]    r_sync_p1;
   logic [3:0]    r_deb_p2;
   logic [3:0]    r_deb_p3;
   logic [7:0]    r_cnt [4];
   logic [NP-1:0] r_pend;
   logic          r_ovf;
   logic [IW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [PW:0]   r_count;

   logic [NP-1:0] w_evt;
   logic [NP-1:0] w_clr;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_head;
   logic          w_push;
   logic          w_pop;
   logic          w_vld;
   logic          w_merge;

   // Stage p0/p1: two-flop synchronizer for the asynchronous key lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_p0 <= '0;
         r_sync_p1 <= '0;
      end else begin
         r_sync_p0 <= key;
         r_sync_p1 <= r_sync_p0;
      end
   end

   // Stage p2: debounce, a level is accepted after DEB_CYCLES consecutive differing cycles; p3 keeps the previous debounced state for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_deb_p2 <= '0;
         r_deb_p3 <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_deb_p3 <= r_deb_p2;
         for (int i = 0; i < 4; i++) begin
            if (r_sync_p1[i] == r_deb_p2[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_deb_p2[i] <= r_sync_p1[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
      end
   end

`ifdef KEY4_ENC_RELEASE_EN
   assign w_evt = {r_deb_p3 & ~r_deb_p2, r_deb_p2 & ~r_deb_p3};
`else
   assign w_evt = r_deb_p2 & ~r_deb_p3;
`endif

   // A new event landing on a bit that is already pending merges and is lost.
   assign w_merge = |(w_evt & r_pend);

   // Priority pick of the lowest pending bit; nothing is pushed while the FIFO is full.
   always_comb begin
      w_idx = '0;
      w_clr = '0;
      for (int i = NP - 1; i >= 0; i--) begin
         if (r_pend[i]) w_idx = IW'(i);
      end
      w_push = (|r_pend) && !r_count[PW];
      if (w_push) w_clr[w_idx] = 1'b1;
   end

   // Pending mask: a set in the same cycle as a clear keeps the bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pend <= '0;
      else     r_pend <= (r_pend & ~w_clr) | w_evt;
   end

   // Sticky overflow flag; a merge in the same cycle as ovf_clr keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_ovf <= 1'b0;
      else if (w_merge) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
   end

   assign ovf = r_ovf;

   assign w_vld = |r_count;
   assign w_pop = w_vld && bus.code_rdy;

   // FIFO storage holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_idx;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head       = r_mem[r_rd];
   assign bus.code_vld = w_vld;
   assign bus.code     = w_vld ? w_head[1:0] : 2'b00;
`ifdef KEY4_ENC_RELEASE_EN
   assign bus.rel      = w_vld ? w_head[2] : 1'b0;
`else
   assign bus.rel      = 1'b0;
`endif

endmodule

// File: tb/tb_key4_enc.sv
// tb_key4_enc: directed stimulus for key4_enc with a scoreboard queue of
// expected {rel, code} entries and a monitor that checks every accepted head.
`timescale 1ns/1ps
module tb_key4_enc;
   localparam int DEB = 4;
`ifdef KEY4_ENC_RELEASE_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key;
   logic       ovf;
   logic       ovf_clr;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   logic       glitch_seen;

   typedef struct {
      logic [2:0] val;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   key4_enc_if bus_if();

   key4_enc #(.DEB_CYCLES(DEB), .FIFO_DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .key     (key),
      .bus     (bus_if),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input logic rel, input logic [1:0] code, input int at);
      exp_t e;
      e.val = {rel, code};
      e.cyc = at;
      sb.push_back(e);
   endtask

   task automatic expect_rel(input logic [1:0] code);
      if (REL_EN) expect_ev(1'b1, code, -1);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst && bus_if.code_vld && bus_if.code_rdy) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got rel=%0d code=%0d, required no event",
                        bus_if.rel, bus_if.code);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("event_value", int'({bus_if.rel, bus_if.code}), int'(e.val));
               if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
            end
         end
      end
   endtask

   initial begin
      rst             = 1'b1;
      key             = 4'hF;
      ovf_clr         = 1'b0;
      bus_if.code_rdy = 1'b1;
      fork
         monitor();
      join_none

      // Reset with all keys held: every output must read 0.
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", int'({bus_if.code_vld, bus_if.rel, bus_if.code, ovf}), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      key = 4'h0;
      @(negedge clk);
      chk("post_reset_outputs", int'({bus_if.code_vld, bus_if.rel, bus_if.code, ovf}), 0);
      tick(10);

      // Single press of key 2: one event, DEB+4 cycles after the edge.
      expect_ev(1'b0, 2'b10, cyc + DEB + 4);
      key[2] = 1'b1;
      tick(20);
      chk("single_drained", sb.size(), 0);
      expect_rel(2'b10);
      key[2] = 1'b0;
      tick(15);

      // Glitch of DEB-1 cycles on key 0 is ignored.
      glitch_seen = 1'b0;
      key[0] = 1'b1;
      tick(DEB - 1);
      key[0] = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus_if.code_vld) glitch_seen = 1'b1;
      end
      chk("glitch_reject_vld", int'(glitch_seen), 0);
      tick(1);

      // Pulse of exactly DEB cycles is accepted.
      expect_ev(1'b0, 2'b00, cyc + DEB + 4);
      key[0] = 1'b1;
      tick(DEB);
      key[0] = 1'b0;
      expect_rel(2'b00);
      tick(20);
      chk("min_pulse_drained", sb.size(), 0);

      // Keys 3 and 1 together: index 1 first, then 3 on the next cycle.
      expect_ev(1'b0, 2'b01, cyc + DEB + 4);
      expect_ev(1'b0, 2'b11, cyc + DEB + 5);
      key = 4'b1010;
      tick(16);
      chk("simul_drained", sb.size(), 0);
      expect_rel(2'b01);
      expect_rel(2'b11);
      key = 4'b0000;
      tick(16);

`ifndef KEY4_ENC_RELEASE_EN
      // Back-pressure: fill the FIFO, then pend and merge on key 0.
      bus_if.code_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         expect_ev(1'b0, 2'(k), -1);
         key[k] = 1'b1;
         tick(12);
      end
      chk("bp_full_vld", int'(bus_if.code_vld), 1);
      chk("bp_head_code", int'(bus_if.code), 0);
      expect_ev(1'b0, 2'b00, -1);
      key[0] = 1'b0;
      tick(12);
      key[0] = 1'b1;
      tick(12);
      chk("bp_pend_no_ovf", int'(ovf), 0);
      key[0] = 1'b0;
      tick(12);
      key[0] = 1'b1;
      tick(12);
      chk("bp_merge_ovf", int'(ovf), 1);
      bus_if.code_rdy = 1'b1;
      tick(12);
      chk("bp_drained", sb.size(), 0);
      chk("ovf_sticky", int'(ovf), 1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", int'(ovf), 0);
      key = 4'b0000;
      tick(12);
`else
      // Press then release of key 2 yields a press entry then a release entry.
      expect_ev(1'b0, 2'b10, -1);
      expect_ev(1'b1, 2'b10, -1);
      key[2] = 1'b1;
      tick(12);
      key[2] = 1'b0;
      tick(12);
      chk("rel_drained", sb.size(), 0);
`endif

      tick(5);
      chk("final_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
